// File: rtl/icap_pkg.sv
// Shared types and constants for the ICAPE2 partial-reconfiguration loader.
// Build option ICAP_BITSWAP_EN (see icap_word_serializer) bit-reverses every ICAP byte.
package icap_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFlush,
      StDone,
      StAbort
   } icap_state_e;

   localparam logic [31:0] ICAP_NOOP = 32'h2000_0000;
   localparam logic [31:0] ICAP_SYNC = 32'hAA99_5566;

   function automatic logic [7:0] bit_rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         r[i] = b[7-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/icap_word_serializer.sv
// Holds one 32-bit word and presents it MSB byte first as BUS_WIDTH-wide slices.
// With ICAP_BITSWAP_EN defined each output byte is bit-reversed; otherwise bytes pass unmodified.
module icap_word_serializer
   import icap_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 clear_i,
   input  logic                 load_i,
   input  logic [31:0]          word_i,
   input  logic                 consume_i,
   output logic                 full_o,
   output logic                 last_o,
   output logic                 room_o,
   output logic [BUS_WIDTH-1:0] byte_o
);

   localparam int unsigned BPW = 32 / BUS_WIDTH;
   localparam int unsigned IdxW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(BPW - 1);

   logic [31:0]          hold_q, hold_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic                 full_q, full_d;
   logic [BUS_WIDTH-1:0] raw;

   always_comb begin
      hold_d = hold_q;
      idx_d  = idx_q;
      full_d = full_q;
      if (clear_i) begin
         full_d = 1'b0;
         idx_d  = '0;
      end else if (load_i) begin
         hold_d = word_i;
         idx_d  = '0;
         full_d = 1'b1;
      end else if (consume_i && full_q) begin
         if (idx_q == IdxLast) begin
            full_d = 1'b0;
            idx_d  = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   // Index 0 selects the most significant slice.
   always_comb begin
      raw = '0;
      for (int i = 0; i < int'(BPW); i++) begin
         if (idx_q == IdxW'(int'(BPW) - 1 - i)) begin
            raw = hold_q[i*BUS_WIDTH +: BUS_WIDTH];
         end
      end
   end

`ifdef ICAP_BITSWAP_EN
   always_comb begin
      byte_o = raw;
      for (int b = 0; b < int'(BUS_WIDTH / 8); b++) begin
         byte_o[b*8 +: 8] = bit_rev8(raw[b*8 +: 8]);
      end
   end
`else
   assign byte_o = raw;
`endif

   assign full_o = full_q;
   assign last_o = (idx_q == IdxLast);
   // Next cycle the holder is free or on its final slice, so a new word may be taken.
   assign room_o = !full_d || (idx_d == IdxLast);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hold_q <= '0;
         idx_q  <= '0;
         full_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         idx_q  <= idx_d;
         full_q <= full_d;
      end
   end

endmodule

// File: rtl/icap_pr_loader.sv
// Streams a partial bitstream into ICAPE2 write cycles, then appends NOOP flush words.
// Byte bit-reversal is selected at build time with ICAP_BITSWAP_EN.
module icap_pr_loader
   import icap_pkg::*;
#(
   parameter int unsigned BUS_WIDTH   = 8,
   parameter int unsigned LEN_W       = 20,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned FLUSH_WORDS = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   input  logic [LEN_W-1:0]     bs_len,
   input  logic                 abort,
   input  logic [31:0]          s_data,
   input  logic                 s_valid,
   output logic                 s_ready,
   output logic                 icap_csib,
   output logic                 icap_rdwrb,
   output logic [BUS_WIDTH-1:0] icap_i,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [LEN_W-1:0]     words_sent
);

   localparam int unsigned WdW = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
   localparam int unsigned FlushW = (FLUSH_WORDS > 1) ? $clog2(FLUSH_WORDS) : 1;
   localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_WORDS - 1);

   icap_state_e          state_q, state_d;
   logic [LEN_W-1:0]     rem_q, rem_d;
   logic [WdW-1:0]       wd_q, wd_d;
   logic [FlushW-1:0]    flush_q, flush_d;
   logic [LEN_W-1:0]     words_sent_q, words_sent_d;
   logic                 csib_q, csib_d;
   logic                 rdwrb_q, rdwrb_d;
   logic [BUS_WIDTH-1:0] icap_i_q, icap_i_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 error_q, error_d;
   logic                 s_ready_q, s_ready_d;

   logic                 accept, go_abort;
   logic                 ser_clear, ser_load, ser_consume;
   logic [31:0]          ser_word;
   logic                 ser_full, ser_last, ser_room;
   logic [BUS_WIDTH-1:0] ser_byte;

   icap_word_serializer #(
      .BUS_WIDTH (BUS_WIDTH)
   ) u_ser (
      .clk_i     (clk),
      .rst_ni    (rstn),
      .clear_i   (ser_clear),
      .load_i    (ser_load),
      .word_i    (ser_word),
      .consume_i (ser_consume),
      .full_o    (ser_full),
      .last_o    (ser_last),
      .room_o    (ser_room),
      .byte_o    (ser_byte)
   );

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      wd_d         = '0;
      flush_d      = flush_q;
      words_sent_d = words_sent_q;
      csib_d       = 1'b1;
      rdwrb_d      = 1'b0;
      icap_i_d     = icap_i_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      error_d      = error_q;
      s_ready_d    = 1'b0;
      ser_clear    = 1'b0;
      ser_load     = 1'b0;
      ser_consume  = 1'b0;
      ser_word     = s_data;
      go_abort     = 1'b0;
      accept       = s_valid && s_ready_q;

      unique case (state_q)
         StIdle: begin
            // abort in the same cycle suppresses start
            if (start && !abort) begin
               error_d      = 1'b0;
               words_sent_d = '0;
               if (bs_len != '0) begin
                  rem_d     = bs_len;
                  busy_d    = 1'b1;
                  s_ready_d = 1'b1;
                  state_d   = StLoad;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         StLoad: begin
            if (abort || (!ser_full && !s_valid && wd_q == WdLast)) begin
               go_abort = 1'b1;
            end else begin
               if (!ser_full && !s_valid) begin
                  wd_d = wd_q + 1'b1;
               end
               if (ser_full) begin
                  ser_consume = 1'b1;
                  csib_d      = 1'b0;
                  icap_i_d    = ser_byte;
                  if (ser_last) begin
                     words_sent_d = words_sent_q + 1'b1;
                  end
               end
               if (accept) begin
                  ser_load = 1'b1;
                  rem_d    = rem_q - 1'b1;
               end else if (ser_full && ser_last && rem_q == '0) begin
                  if (FLUSH_WORDS == 0) begin
                     state_d = StDone;
                  end else begin
                     ser_load = 1'b1;
                     ser_word = ICAP_NOOP;
                     flush_d  = FlushLast;
                     state_d  = StFlush;
                  end
               end
               s_ready_d = (state_d == StLoad) && (rem_d != '0) && ser_room;
            end
         end
         StFlush: begin
            if (abort) begin
               go_abort = 1'b1;
            end else begin
               ser_consume = 1'b1;
               csib_d      = 1'b0;
               icap_i_d    = ser_byte;
               if (ser_last) begin
                  if (flush_q != '0) begin
                     ser_load = 1'b1;
                     ser_word = ICAP_NOOP;
                     flush_d  = flush_q - 1'b1;
                  end else begin
                     state_d = StDone;
                  end
               end
            end
         end
         StDone, StAbort: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (go_abort) begin
         ser_clear = 1'b1;
         error_d   = 1'b1;
         csib_d    = 1'b1;
         s_ready_d = 1'b0;
         state_d   = StAbort;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         rem_q        <= '0;
         wd_q         <= '0;
         flush_q      <= '0;
         words_sent_q <= '0;
         csib_q       <= 1'b1;
         rdwrb_q      <= 1'b0;
         icap_i_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         s_ready_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rem_q        <= rem_d;
         wd_q         <= wd_d;
         flush_q      <= flush_d;
         words_sent_q <= words_sent_d;
         csib_q       <= csib_d;
         rdwrb_q      <= rdwrb_d;
         icap_i_q     <= icap_i_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         error_q      <= error_d;
         s_ready_q    <= s_ready_d;
      end
   end

   assign s_ready    = s_ready_q;
   assign icap_csib  = csib_q;
   assign icap_rdwrb = rdwrb_q;
   assign icap_i     = icap_i_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign words_sent = words_sent_q;

endmodule

// File: tb/tb_icap_pr_loader.sv
// Directed bench for icap_pr_loader (BUS_WIDTH=8); expected bytes follow ICAP_BITSWAP_EN.
module tb_icap_pr_loader;
   import icap_pkg::*;

   localparam int unsigned BusW       = 8;
   localparam int unsigned LenW       = 20;
   localparam int unsigned Timeout    = 20;
   localparam int unsigned FlushWords = 2;

   logic            clk = 1'b0;
   logic            rstn = 1'b0;
   logic            start = 1'b0;
   logic            abort = 1'b0;
   logic [LenW-1:0] bs_len = '0;
   logic [31:0]     s_data = '0;
   logic            s_valid = 1'b0;
   logic            s_ready, icap_csib, icap_rdwrb, busy, done, error;
   logic [BusW-1:0] icap_i;
   logic [LenW-1:0] words_sent;

   icap_pr_loader #(
      .BUS_WIDTH   (BusW),
      .LEN_W       (LenW),
      .TIMEOUT     (Timeout),
      .FLUSH_WORDS (FlushWords)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .start      (start),
      .bs_len     (bs_len),
      .abort      (abort),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .icap_csib  (icap_csib),
      .icap_rdwrb (icap_rdwrb),
      .icap_i     (icap_i),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .words_sent (words_sent)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] words[$];
   logic [7:0]  got[$];
   logic [7:0]  exp_bytes[$];
   int          acc, stall_at, stall_left, cyc, first_cyc, last_cyc, done_cnt, rdwr_bad;
   bit          done_seen;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
      end
   endtask

   function automatic logic [7:0] eb(input logic [7:0] b);
`ifdef ICAP_BITSWAP_EN
      return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
`else
      return b;
`endif
   endfunction

   task automatic push_exp(input logic [31:0] w);
      exp_bytes.push_back(eb(w[31:24]));
      exp_bytes.push_back(eb(w[23:16]));
      exp_bytes.push_back(eb(w[15:8]));
      exp_bytes.push_back(eb(w[7:0]));
   endtask

   task automatic clear_capture();
      got.delete();
      exp_bytes.delete();
      words.delete();
      acc = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      done_cnt = 0; rdwr_bad = 0; done_seen = 1'b0;
      stall_at = -1; stall_left = 0;
      s_valid = 1'b0;
   endtask

   // One clock: handshake seen at the edge, outputs sampled on the falling edge, then new inputs.
   task automatic step();
      logic hs;
      hs = s_valid & s_ready;
      @(posedge clk);
      if (hs) acc++;
      @(negedge clk);
      cyc++;
      if (!icap_csib) begin
         got.push_back(icap_i);
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
      end
      if (icap_rdwrb) rdwr_bad++;
      if (done) begin
         done_cnt++;
         done_seen = 1'b1;
      end
      start = 1'b0;
      abort = 1'b0;
      if (acc == stall_at && stall_left > 0) begin
         s_valid = 1'b0;
         stall_left--;
      end else if (acc < words.size()) begin
         s_valid = 1'b1;
         s_data  = words[acc];
      end else begin
         s_valid = 1'b0;
      end
   endtask

   task automatic run_until_done(input int budget);
      for (int i = 0; i < budget && !done_seen; i++) step();
   endtask

   task automatic check_bytes(input string tag);
      check_eq({tag, "_nbytes"}, got.size(), exp_bytes.size());
      for (int i = 0; i < got.size() && i < exp_bytes.size(); i++) begin
         check_eq($sformatf("%s_b%0d", tag, i), got[i], exp_bytes[i]);
      end
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_csib"}, icap_csib, 1);
      check_eq({tag, "_rdwrb"}, icap_rdwrb, 0);
      check_eq({tag, "_icap_i"}, icap_i, 0);
      check_eq({tag, "_s_ready"}, s_ready, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_error"}, error, 0);
      check_eq({tag, "_words_sent"}, words_sent, 0);
   endtask

   task automatic load_std_words(input bit extra);
      words.push_back(32'hAA99_5566);
      words.push_back(32'h3000_8001);
      words.push_back(32'h0000_000D);
      if (extra) words.push_back(32'hDEAD_BEEF);
      push_exp(32'hAA99_5566);
      push_exp(32'h3000_8001);
      push_exp(32'h0000_000D);
      push_exp(ICAP_NOOP);
      push_exp(ICAP_NOOP);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      clear_capture();
      rstn = 1'b0;
      repeat (3) step();
      check_reset("rst");
      rstn = 1'b1;
      step();

      // Continuous stream, one surplus word that must stay unconsumed
      clear_capture();
      load_std_words(1'b1);
      bs_len = 3;
      start  = 1'b1;
      step();
      check_eq("t1_busy", busy, 1);
      check_eq("t1_s_ready", s_ready, 1);
      run_until_done(100);
      check_eq("t1_done", done_seen, 1);
      check_bytes("t1");
      check_eq("t1_contig", last_cyc - first_cyc + 1, got.size());
      check_eq("t1_words_sent", words_sent, 3);
      check_eq("t1_busy_end", busy, 0);
      check_eq("t1_error", error, 0);
      step();
      step();
      check_eq("t1_accepted", acc, 3);
      check_eq("t1_done_width", done_cnt, 1);
      check_eq("t1_rdwrb", rdwr_bad, 0);

      // Five-cycle stall between words 1 and 2
      clear_capture();
      load_std_words(1'b0);
      stall_at   = 1;
      stall_left = 5;
      bs_len     = 3;
      start      = 1'b1;
      step();
      run_until_done(100);
      check_eq("t2_done", done_seen, 1);
      check_bytes("t2");
      check_eq("t2_gap_seen", (last_cyc - first_cyc + 1) > got.size(), 1);
      check_eq("t2_rdwrb", rdwr_bad, 0);
      check_eq("t2_error", error, 0);
      check_eq("t2_words_sent", words_sent, 3);

      // Watchdog: stream dries up after the first of two words
      clear_capture();
      words.push_back(32'hAA99_5566);
      words.push_back(32'h3000_8001);
      stall_at   = 1;
      stall_left = 1000;
      bs_len     = 2;
      start      = 1'b1;
      step();
      run_until_done(200);
      check_eq("t3_done", done_seen, 1);
      check_eq("t3_error", error, 1);
      check_eq("t3_csib", icap_csib, 1);
      check_eq("t3_busy", busy, 0);
      check_eq("t3_words_sent", words_sent, 1);
      check_eq("t3_nbytes", got.size(), 4);

      // Zero-length load: immediate done and error cleared
      clear_capture();
      bs_len = 0;
      start  = 1'b1;
      step();
      check_eq("t6_done", done, 1);
      check_eq("t6_error_clr", error, 0);
      check_eq("t6_busy", busy, 0);
      step();
      check_eq("t6_done_width", done, 0);
      check_eq("t6_nbytes", got.size(), 0);

      // Abort while the third byte of word 2 is on the bus
      clear_capture();
      words.push_back(ICAP_SYNC);
      words.push_back(32'h3000_8001);
      words.push_back(32'h0000_000D);
      words.push_back(32'h1234_5678);
      bs_len = 4;
      start  = 1'b1;
      step();
      for (int i = 0; i < 60 && got.size() < 7; i++) step();
      check_eq("t4_reach", got.size(), 7);
      abort = 1'b1;
      step();
      check_eq("t4_csib_next", icap_csib, 1);
      check_eq("t4_error", error, 1);
      run_until_done(10);
      check_eq("t4_done", done_seen, 1);
      check_eq("t4_busy", busy, 0);
      check_eq("t4_words_sent", words_sent, 1);
      check_eq("t4_nbytes", got.size(), 7);

      // New start clears error; then reset lands in the middle of the flush
      clear_capture();
      words.push_back(ICAP_SYNC);
      bs_len = 1;
      start  = 1'b1;
      step();
      check_eq("t5_err_clr", error, 0);
      check_eq("t5_busy", busy, 1);
      for (int i = 0; i < 40 && got.size() < 6; i++) step();
      check_eq("t5_in_flush", got.size(), 6);
      check_eq("t5_noop0", got[4], eb(8'h20));
      rstn = 1'b0;
      step();
      check_reset("t5_rst");
      rstn = 1'b1;
      repeat (4) step();
      check_eq("t5_no_done", done_cnt, 0);
      check_eq("t5_csib_idle", icap_csib, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
